// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline buffers.
// Occupancy encoding and default bundle widths for stage wrappers.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 12;
    localparam int CNT_W_DEF  = 16;

    typedef logic [1:0] state_t;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready bundle between two pipeline stages.
// master drives valid/data/ctrl, slave drives ready.
interface pipe_stage_buf_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );

endinterface

// File: rtl/pipe_slot.sv
// One buffer entry: valid + control + payload.
// clear kills valid/ctrl only; the payload is left as-is.
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // entry state; a clear overrides a load so a killed entry stays a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage register with a 2-entry skid buffer.
// in_ready is registered so stall never ripples upstream combinationally.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_buf_if.slave  up,
    pipe_stage_buf_if.master dn,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic              in_ready;
    logic              acc;
    logic              pop;
    logic              out_valid;

    logic              main_load;
    logic              main_clr;
    logic              main_sel_skid;
    logic              skid_load;
    logic              skid_clr;

    logic              main_v;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_v;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;

    assign acc = up.valid & in_ready;
    assign pop = out_valid & dn.ready;

    // occupancy register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // occupancy transitions; flush always lands in EMPTY
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_EMPTY: if (acc) state_nxt = ST_ONE;
            ST_ONE: begin
                if (acc && !pop) state_nxt = ST_FULL;
                else if (pop && !acc) state_nxt = ST_EMPTY;
            end
            ST_FULL: if (pop) state_nxt = ST_ONE;
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) state_nxt = ST_EMPTY;
    end

    // slot load/clear strobes derived from occupancy and handshakes
    always_comb begin
        main_load     = 1'b0;
        main_clr      = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        unique case (state)
            ST_EMPTY: main_load = acc;
            ST_ONE: begin
                main_load = acc & pop;
                skid_load = acc & ~pop;
                main_clr  = pop & ~acc;
            end
            ST_FULL: begin
                main_load     = pop;
                main_sel_skid = pop & skid_v;
                skid_clr      = pop;
            end
            default: begin
                main_clr = 1'b1;
                skid_clr = 1'b1;
            end
        endcase
        if (flush) begin
            main_load = 1'b0;
            skid_load = 1'b0;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end
    end

    assign main_d_data = main_sel_skid ? skid_data : up.data;
    assign main_d_ctrl = main_sel_skid ? skid_ctrl : up.ctrl;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (main_clr),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .valid  (main_v),
        .data   (main_data),
        .ctrl   (main_ctrl)
    );

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clr),
        .d_data (up.data),
        .d_ctrl (up.ctrl),
        .valid  (skid_v),
        .data   (skid_data),
        .ctrl   (skid_ctrl)
    );

    // ready for the next cycle unless we are about to be full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= (state_nxt != ST_FULL);
        end
    end

    // saturating count of cycles the head is blocked downstream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !dn.ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign out_valid = (state != ST_EMPTY) & main_v;
    assign up.ready  = in_ready;
    assign dn.valid  = out_valid;
    assign dn.data   = main_data;
    assign dn.ctrl   = out_valid ? main_ctrl : '0;

endmodule
